// File: rtl/dm_arbiter.sv
// dm_arbiter -- shares the single data-memory port between the CPU stage-3
// access and a debug/loader port, and provides a debug halt.
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   cpu_rd, cpu_wr, cpu_addr,
//   cpu_wdata                          CPU memory request
//   cpu_stall, cpu_rdata               CPU hold and read data
//   dbg_req, dbg_we, dbg_addr,
//   dbg_wdata, dbg_halt                debug request and halt level
//   dbg_gnt, dbg_rdata, halted         debug grant, read data, halt status
//   mem_we, mem_addr, mem_wdata,
//   mem_rdata                          data-memory port (combinational read)
//
// state | meaning
// ------+------------------------------------------------------------
// RUN   | CPU owns the port; a pending debug request ages in wait_cnt
// DBG   | one-cycle debug access; a CPU request in this cycle stalls
// HALT  | CPU frozen; debug requests are granted as they arrive
module dm_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cpu_rd,
   input  logic       cpu_wr,
   input  logic [7:0] cpu_addr,
   input  logic [7:0] cpu_wdata,
   output logic       cpu_stall,
   output logic [7:0] cpu_rdata,
   input  logic       dbg_req,
   input  logic       dbg_we,
   input  logic [7:0] dbg_addr,
   input  logic [7:0] dbg_wdata,
   input  logic       dbg_halt,
   output logic       dbg_gnt,
   output logic [7:0] dbg_rdata,
   output logic       halted,
   output logic       mem_we,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   input  logic [7:0] mem_rdata
);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_DBG  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam logic [2:0] LIMIT_M1 = 3'(STARVE_LIMIT - 1);

   state_t     state_q, state_d;
   logic [2:0] wait_cnt, wait_d;
   logic       cpu_busy;
   logic       we_c;

   assign cpu_busy = cpu_rd | cpu_wr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         wait_cnt <= 3'd0;
      end else begin
         state_q  <= state_d;
         wait_cnt <= wait_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cpu_stall = 1'b0;
      dbg_gnt   = 1'b0;
      halted    = 1'b0;
      we_c      = 1'b0;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      case (state_q)
         ST_RUN: begin
            we_c = cpu_wr;
            if (dbg_halt)
               state_d = ST_HALT;
            else if (dbg_req && (!cpu_busy || wait_cnt >= LIMIT_M1))
               state_d = ST_DBG;
         end
         ST_DBG: begin
            we_c      = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            dbg_gnt   = 1'b1;
            cpu_stall = cpu_busy;
            state_d   = dbg_halt ? ST_HALT : ST_RUN;
         end
         ST_HALT: begin
            halted    = 1'b1;
            cpu_stall = 1'b1;
            dbg_gnt   = dbg_req;
            we_c      = dbg_req & dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            if (!dbg_halt)
               state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Counter ages only while the CPU actually holds the port against a
   // pending request; a grant or a withdrawn request starts it over.
   always_comb begin
      wait_d = wait_cnt;
      if (!dbg_req || dbg_gnt)
         wait_d = 3'd0;
      else if (state_q == ST_RUN && cpu_busy && wait_cnt != 3'd7)
         wait_d = wait_cnt + 3'd1;
   end

   // Reset lands in RUN, where the strobe would follow cpu_wr; masking it
   // keeps the memory untouched for as long as rst_n is held low.
   assign mem_we    = we_c & rst_n;
   assign cpu_rdata = mem_rdata;
   assign dbg_rdata = mem_rdata;

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cpu_rd, cpu_wr;
   logic [7:0] cpu_addr, cpu_wdata;
   logic       cpu_stall;
   logic [7:0] cpu_rdata;
   logic       dbg_req, dbg_we;
   logic [7:0] dbg_addr, dbg_wdata;
   logic       dbg_halt;
   logic       dbg_gnt;
   logic [7:0] dbg_rdata;
   logic       halted;
   logic       mem_we;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;

   logic [7:0] mem [0:255] = '{default: 8'h00};

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   always @(posedge clk)
      if (mem_we) mem[mem_addr] <= mem_wdata;

   assign mem_rdata = mem[mem_addr];

   dm_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_halt(dbg_halt), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .halted(halted),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic dbg_set(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
      dbg_req   = req;
      dbg_we    = we;
      dbg_addr  = a;
      dbg_wdata = d;
   endtask

   initial begin
      rst_n = 1'b0;
      cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
      dbg_set(0, 0, 8'h00, 8'h00);
      dbg_halt = 0;

      // reset state
      tick(); tick();
      chk("rst_halted", {7'd0, halted}, 8'd0);
      chk("rst_stall", {7'd0, cpu_stall}, 8'd0);
      chk("rst_gnt", {7'd0, dbg_gnt}, 8'd0);
      chk("rst_we", {7'd0, mem_we}, 8'd0);
      rst_n = 1'b1;
      tick();

      // idle-CPU debug write 0xA5 -> 0x10
      dbg_set(1, 1, 8'h10, 8'hA5);
      #1;
      chk("idle_gnt_c0", {7'd0, dbg_gnt}, 8'd0);
      chk("idle_we_c0", {7'd0, mem_we}, 8'd0);
      tick();
      chk("idle_gnt_c1", {7'd0, dbg_gnt}, 8'd1);
      chk("idle_we_c1", {7'd0, mem_we}, 8'd1);
      chk("idle_addr_c1", mem_addr, 8'h10);
      chk("idle_stall_c1", {7'd0, cpu_stall}, 8'd0);
      dbg_req = 0;
      tick();
      chk("idle_gnt_c2", {7'd0, dbg_gnt}, 8'd0);
      chk("idle_stall_c2", {7'd0, cpu_stall}, 8'd0);
      chk("idle_mem10", mem[8'h10], 8'hA5);

      // preload 0x3C -> 0x20 the same way
      dbg_set(1, 1, 8'h20, 8'h3C);
      tick();
      chk("pre_gnt", {7'd0, dbg_gnt}, 8'd1);
      dbg_req = 0;
      tick();
      chk("pre_mem20", mem[8'h20], 8'h3C);

      // CPU reading every cycle; debug read of 0x20 granted in cycle 5
      cpu_rd = 1; cpu_addr = 8'h30;
      dbg_set(1, 0, 8'h20, 8'h00);
      for (int i = 1; i <= 4; i++) begin
         #1;
         chk($sformatf("starve_gnt_c%0d", i), {7'd0, dbg_gnt}, 8'd0);
         chk($sformatf("starve_stall_c%0d", i), {7'd0, cpu_stall}, 8'd0);
         tick();
      end
      chk("starve_gnt_c5", {7'd0, dbg_gnt}, 8'd1);
      chk("starve_stall_c5", {7'd0, cpu_stall}, 8'd1);
      chk("starve_we_c5", {7'd0, mem_we}, 8'd0);
      chk("starve_rdata_c5", dbg_rdata, 8'h3C);
      chk("starve_cpu_rdata_c5", cpu_rdata, 8'h3C);
      dbg_req = 0;
      tick();
      chk("starve_gnt_c6", {7'd0, dbg_gnt}, 8'd0);
      chk("starve_stall_c6", {7'd0, cpu_stall}, 8'd0);

      // request withdrawn after two waiting cycles: no effect, counter restarts
      dbg_set(1, 1, 8'h40, 8'h77);
      tick(); tick();
      dbg_req = 0;
      #1;
      chk("drop_we", {7'd0, mem_we}, 8'd0);
      tick();
      chk("drop_gnt", {7'd0, dbg_gnt}, 8'd0);
      chk("drop_mem40", mem[8'h40], 8'h00);
      dbg_req = 1;
      for (int i = 1; i <= 4; i++) begin
         #1;
         chk($sformatf("rereq_gnt_c%0d", i), {7'd0, dbg_gnt}, 8'd0);
         tick();
      end
      chk("rereq_gnt_c5", {7'd0, dbg_gnt}, 8'd1);
      chk("rereq_we_c5", {7'd0, mem_we}, 8'd1);
      dbg_req = 0;
      tick();
      chk("rereq_mem40", mem[8'h40], 8'h77);

      // halt while CPU writes (rd+wr counts as write)
      cpu_rd = 1; cpu_wr = 1; cpu_addr = 8'h50; cpu_wdata = 8'hEE;
      dbg_halt = 1;
      #1;
      chk("halt_pre_we", {7'd0, mem_we}, 8'd1);
      chk("halt_pre_halted", {7'd0, halted}, 8'd0);
      tick();
      chk("halt_halted", {7'd0, halted}, 8'd1);
      chk("halt_stall", {7'd0, cpu_stall}, 8'd1);
      chk("halt_we_idle", {7'd0, mem_we}, 8'd0);
      chk("halt_gnt_idle", {7'd0, dbg_gnt}, 8'd0);
      chk("halt_mem50", mem[8'h50], 8'hEE);
      for (int k = 0; k < 3; k++) begin
         dbg_set(1, 1, 8'h60 + 8'(k), 8'h11 * 8'(k + 1));
         #1;
         chk($sformatf("b2b_gnt_%0d", k), {7'd0, dbg_gnt}, 8'd1);
         chk($sformatf("b2b_we_%0d", k), {7'd0, mem_we}, 8'd1);
         tick();
      end
      dbg_req = 0;
      #1;
      chk("b2b_mem60", mem[8'h60], 8'h11);
      chk("b2b_mem61", mem[8'h61], 8'h22);
      chk("b2b_mem62", mem[8'h62], 8'h33);
      chk("b2b_stall", {7'd0, cpu_stall}, 8'd1);

      // leave halt
      cpu_rd = 0; cpu_wr = 0;
      dbg_halt = 0;
      tick();
      chk("unhalt_halted", {7'd0, halted}, 8'd0);
      chk("unhalt_stall", {7'd0, cpu_stall}, 8'd0);

      // halt and request together: HALT wins, access granted in final HALT cycle
      cpu_wr = 1; cpu_addr = 8'h71; cpu_wdata = 8'h01;
      dbg_halt = 1;
      dbg_set(1, 1, 8'h70, 8'h99);
      #1;
      chk("both_gnt_c0", {7'd0, dbg_gnt}, 8'd0);
      tick();
      chk("both_halted", {7'd0, halted}, 8'd1);
      chk("both_gnt", {7'd0, dbg_gnt}, 8'd1);
      chk("both_addr", mem_addr, 8'h70);
      dbg_halt = 0;
      #1;
      chk("both_last_gnt", {7'd0, dbg_gnt}, 8'd1);
      chk("both_last_we", {7'd0, mem_we}, 8'd1);
      tick();
      dbg_req = 0;
      cpu_wr = 0;
      #1;
      chk("both_run_halted", {7'd0, halted}, 8'd0);
      chk("both_run_stall", {7'd0, cpu_stall}, 8'd0);
      chk("both_run_gnt", {7'd0, dbg_gnt}, 8'd0);
      chk("both_mem70", mem[8'h70], 8'h99);

      // reset pulsed mid-HALT while both sides want to write
      dbg_halt = 1;
      tick();
      chk("rh_halted", {7'd0, halted}, 8'd1);
      dbg_set(1, 1, 8'h80, 8'h55);
      cpu_wr = 1; cpu_addr = 8'h81; cpu_wdata = 8'h66;
      #1;
      chk("rh_we_before", {7'd0, mem_we}, 8'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rh_async_halted", {7'd0, halted}, 8'd0);
      chk("rh_async_stall", {7'd0, cpu_stall}, 8'd0);
      chk("rh_async_we", {7'd0, mem_we}, 8'd0);
      chk("rh_async_gnt", {7'd0, dbg_gnt}, 8'd0);
      tick();
      chk("rh_mem80", mem[8'h80], 8'h00);
      chk("rh_mem81", mem[8'h81], 8'h00);
      dbg_set(0, 0, 8'h00, 8'h00);
      cpu_wr = 0;
      dbg_halt = 0;
      rst_n = 1'b1;
      tick();
      chk("rh_after_halted", {7'd0, halted}, 8'd0);
      chk("rh_after_stall", {7'd0, cpu_stall}, 8'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, max consecutive CPU-won cycles a pending debug request waits (legal 1-7).
REQ-002 clk  input  1  rising-edge clock shared with the pipeline.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 cpu_rd  input  1  stage-3 data-memory read request.
REQ-005 cpu_wr  input  1  stage-3 data-memory write request.
REQ-006 cpu_addr  input  8  CPU memory address (SP, R0 or operand, already muxed).
REQ-007 cpu_wdata  input  8  CPU write data.
REQ-008 cpu_stall  output  1  CPU access not performed this cycle; pipeline holds PC and stage registers.
REQ-009 cpu_rdata  output  8  read data returned to the CPU.
REQ-010 dbg_req  input  1  debug/loader access request, held until granted.
REQ-011 dbg_we  input  1  debug access is a write.
REQ-012 dbg_addr  input  8  debug address.
REQ-013 dbg_wdata  input  8  debug write data.
REQ-014 dbg_halt  input  1  level request to freeze the CPU.
REQ-015 dbg_gnt  output  1  debug access performed this cycle.
REQ-016 dbg_rdata  output  8  read data for the debug port, valid when dbg_gnt=1.
REQ-017 halted  output  1  arbiter is in HALT.
REQ-018 mem_we  output  1  write strobe to data memory (write on clk edge).
REQ-019 mem_addr  output  8  data-memory address.
REQ-020 mem_wdata  output  8  data-memory write data.
REQ-021 mem_rdata  input  8  combinational read data from data memory.

Function
REQ-022 The block SHALL implement a registered FSM with states RUN, DBG, HALT; memory-port muxing SHALL be combinational from the current state.
REQ-023 RUN: port driven by CPU (mem_we=cpu_wr, mem_addr=cpu_addr, mem_wdata=cpu_wdata); cpu_stall=0; dbg_gnt=0.
REQ-024 DBG: port driven by debug (mem_we=dbg_we); dbg_gnt=1; cpu_stall=cpu_rd|cpu_wr; DBG SHALL last exactly one cycle.
REQ-025 HALT: cpu_stall=1 regardless of CPU requests; dbg_gnt=dbg_req; port driven by debug when dbg_req=1, else mem_we=0; halted=1.
REQ-026 cpu_rdata and dbg_rdata SHALL both equal mem_rdata every cycle; only grant/stall qualify validity.
REQ-027 Pending-wait counter wait_cnt (3 bits) SHALL increment each RUN cycle with dbg_req=1 and (cpu_rd|cpu_wr)=1, saturate at 7, and clear on any cycle with dbg_gnt=1.
REQ-028 RUN->DBG at edge when dbg_req=1 and dbg_halt=0 and ((cpu_rd|cpu_wr)=0 or wait_cnt>=STARVE_LIMIT-1).
REQ-029 RUN->HALT at edge when dbg_halt=1; dbg_halt SHALL take priority over the RUN->DBG transition.
REQ-030 DBG->HALT when dbg_halt=1, otherwise DBG->RUN.
REQ-031 HALT->RUN at edge when dbg_halt=0; a debug access granted in that final HALT cycle SHALL complete normally.
REQ-032 A debug request SHALL never wait more than STARVE_LIMIT+1 cycles in RUN with dbg_halt=0.
REQ-033 Requests with cpu_rd=cpu_wr=1 SHALL be treated as a write.
REQ-034 A debug request dropped before grant SHALL be discarded with no memory effect; wait_cnt clears when dbg_req=0.

Reset
REQ-035 rst_n=0 SHALL force state RUN and wait_cnt=0 immediately, independent of clk.
REQ-036 During and after reset with inputs low: cpu_stall=0, dbg_gnt=0, halted=0, mem_we=0.
REQ-037 Reset asserted in DBG or HALT SHALL abort the state without a further memory write after rst_n falls.

Verification
REQ-038 Idle CPU, dbg_req=1, dbg_we=1, addr 0x10, data 0xA5 -> dbg_gnt high next cycle for one cycle, mem[0x10]=0xA5, cpu_stall=0 throughout.
REQ-039 CPU reading every cycle, dbg_req=1 read at 0x20, STARVE_LIMIT=4 -> dbg_gnt in cycle 5 after request, cpu_stall=1 exactly that cycle, dbg_rdata=mem[0x20].
REQ-040 dbg_halt=1 with CPU writing -> halted=1 next cycle, cpu_stall=1 and mem_we=0 while dbg_req=0; three back-to-back debug writes each granted in one cycle.
REQ-041 dbg_halt and dbg_req rise same cycle -> HALT entered (not DBG), access granted in HALT; dbg_halt low -> RUN next edge, cpu_stall=0.
REQ-042 rst_n pulsed low mid-HALT -> halted=0, cpu_stall=0 asynchronously, no write on subsequent edge while rst_n=0.
